// File: rtl/multi_debouncer.sv
// ----------------------------------------------------------------------------
// multi_debouncer
//   N-channel switch/button debouncer. Each channel has its own input
//   synchroniser and confirm FSM. One prescaler is shared by all channels and
//   produces the sample tick. Every channel emits a one-cycle rise/fall pulse
//   when it accepts a new debounced level.
//
// Parameters
//   CHANNELS    number of independent input channels (>=1)
//   SYNC_STAGES synchroniser flops per channel (>=2)
//   PRESCALE    clk cycles per sample tick (>=1)
//   CNT_WIDTH   width of threshold / confirm counter
//   RESET_VAL   reset level of sync chain and dbnc_data (0 or 1)
//
// Ports
//   clk        system clock, posedge
//   reset_n    asynchronous reset, active low
//   en         1 = run, 0 = freeze prescaler and channel FSMs
//   thresh     consecutive mismatching ticks needed to accept (0 acts as 1)
//   din        raw asynchronous inputs
//   dbnc_data  debounced levels
//   rise       one-cycle pulse on a 0->1 accept
//   fall       one-cycle pulse on a 1->0 accept
//   any_change OR of all rise/fall bits, same cycle
// ----------------------------------------------------------------------------
module multi_debouncer #(
   parameter int CHANNELS    = 4,
   parameter int SYNC_STAGES = 2,
   parameter int PRESCALE    = 16,
   parameter int CNT_WIDTH   = 8,
   parameter int RESET_VAL   = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 en,
   input  logic [CNT_WIDTH-1:0] thresh,
   input  logic [CHANNELS-1:0]  din,
   output logic [CHANNELS-1:0]  dbnc_data,
   output logic [CHANNELS-1:0]  rise,
   output logic [CHANNELS-1:0]  fall,
   output logic                 any_change
);

   localparam int   PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic L_RV = (RESET_VAL != 0);

   typedef enum logic {ST_STABLE, ST_CONFIRM} state_t;

   logic [SYNC_STAGES-1:0][CHANNELS-1:0] r_sync;
   logic [PW-1:0]                        r_presc;
   logic [CHANNELS-1:0]                  r_dbnc;
   logic [CHANNELS-1:0]                  r_rise;
   logic [CHANNELS-1:0]                  r_fall;
   state_t                               r_state   [CHANNELS];
   logic [CNT_WIDTH-1:0]                 r_cnt     [CHANNELS];

   state_t                               w_state_nxt [CHANNELS];
   logic [CNT_WIDTH-1:0]                 w_cnt_nxt   [CHANNELS];
   logic [CHANNELS-1:0]                  w_accept;
   logic [CHANNELS-1:0]                  w_s;
   logic [CNT_WIDTH-1:0]                 w_n;
   logic                                 w_tick;

   assign w_s    = r_sync[SYNC_STAGES-1];
   assign w_n    = (thresh == '0) ? CNT_WIDTH'(1) : thresh;
   assign w_tick = en && (r_presc == '0);

   // Synchroniser runs regardless of en.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= {(SYNC_STAGES*CHANNELS){L_RV}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], din};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_presc <= PW'(PRESCALE-1);
      end else if (en) begin
         if (r_presc == '0) r_presc <= PW'(PRESCALE-1);
         else               r_presc <= r_presc - 1'b1;
      end
   end

   // Next-state for every channel; nothing moves off a tick.
   always_comb begin
      logic [CNT_WIDTH:0] v_inc;
      v_inc    = '0;
      w_accept = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         w_state_nxt[i] = r_state[i];
         w_cnt_nxt[i]   = r_cnt[i];
         v_inc          = {1'b0, r_cnt[i]} + 1'b1;
         if (w_tick) begin
            unique case (r_state[i])
               ST_STABLE: begin
                  if (w_s[i] != r_dbnc[i]) begin
                     if (w_n == CNT_WIDTH'(1)) begin
                        w_accept[i] = 1'b1;
                     end else begin
                        w_state_nxt[i] = ST_CONFIRM;
                        w_cnt_nxt[i]   = CNT_WIDTH'(1);
                     end
                  end
               end
               ST_CONFIRM: begin
                  if (w_s[i] == r_dbnc[i]) begin
                     w_state_nxt[i] = ST_STABLE;
                     w_cnt_nxt[i]   = '0;
                  end else if (v_inc >= {1'b0, w_n}) begin
                     // >= rather than == so a live drop of thresh below cnt
                     // still accepts on the next mismatching tick.
                     w_accept[i]    = 1'b1;
                     w_state_nxt[i] = ST_STABLE;
                     w_cnt_nxt[i]   = '0;
                  end else begin
                     w_cnt_nxt[i]   = v_inc[CNT_WIDTH-1:0];
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            r_state[i] <= ST_STABLE;
            r_cnt[i]   <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            r_state[i] <= w_state_nxt[i];
            r_cnt[i]   <= w_cnt_nxt[i];
         end
      end
   end

   // Pulses are rewritten every cycle so they last exactly one clk.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dbnc <= {CHANNELS{L_RV}};
         r_rise <= '0;
         r_fall <= '0;
      end else begin
         r_dbnc <= (r_dbnc & ~w_accept) | (w_s & w_accept);
         r_rise <= w_accept &  w_s;
         r_fall <= w_accept & ~w_s;
      end
   end

   assign dbnc_data  = r_dbnc;
   assign rise       = r_rise;
   assign fall       = r_fall;
   assign any_change = |(r_rise | r_fall);

endmodule
